// File: rtl/xc_malu_mdr_seq_if.sv
// Request/response bundle between a requester and the sequential mul/div unit.
interface xc_malu_mdr_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            valid;
    logic [3:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            ready;
    logic [XLEN-1:0] result;

    modport master (
        output flush, valid, op, rs1, rs2,
        input  busy, ready, result
    );

    modport slave (
        input  flush, valid, op, rs1, rs2,
        output busy, ready, result
    );
endinterface

// File: rtl/xc_malu_mdr_seq.sv
// Sequential multiply / divide / carry-less multiply: one operand bit per cycle
// through a shared 2*XLEN accumulator, sequenced by an IDLE/BUSY/DONE FSM.
module xc_malu_mdr_seq #(
    parameter int XLEN     = 32,
    parameter bit EARLY_DZ = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    xc_malu_mdr_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_DIVU   = 4'd5;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_CLMUL  = 4'd8;
    localparam logic [3:0] OP_CLMULH = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [3:0]        op_r;
    logic [XLEN-1:0]   rs1_r;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] addend;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;
    logic [CW-1:0]     count;
    logic              sub_last, neg_q, neg_r, dz;
    logic              accept, last, op_is_div, op_legal, r_is_div, r_is_cl;
    logic              div_sgn, s1_in, s2_in, mul_s1_in;

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    // Sign correction and divide-by-zero override are applied only when the result is read.
    function automatic logic [XLEN-1:0] pick_result(
        input logic [3:0]        o,
        input logic [2*XLEN-1:0] a,
        input logic [XLEN-1:0]   src1,
        input logic              nq,
        input logic              nr,
        input logic              z
    );
        logic [XLEN-1:0] quo, rem;
        quo = z ? '1   : negate_if(a[XLEN-1:0], nq);
        rem = z ? src1 : negate_if(a[2*XLEN-1:XLEN], nr);
        case (o)
            OP_MUL, OP_CLMUL:                        return a[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU, OP_CLMULH: return a[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                         return quo;
            OP_REM, OP_REMU:                         return rem;
            default:                                 return '0;
        endcase
    endfunction

    assign accept    = bus.valid && !bus.flush;
    assign last      = (count == CW'(XLEN - 1));
    assign op_is_div = (bus.op[3:2] == 2'b01);
    assign op_legal  = (bus.op <= OP_CLMULH);
    assign r_is_div  = (op_r[3:2] == 2'b01);
    assign r_is_cl   = (op_r == OP_CLMUL) || (op_r == OP_CLMULH);

    always_comb begin
        div_sgn   = (bus.op == OP_DIV) || (bus.op == OP_REM);
        s1_in     = div_sgn && bus.rs1[XLEN-1];
        s2_in     = div_sgn && bus.rs2[XLEN-1];
        mul_s1_in = (bus.op == OP_MULH) || (bus.op == OP_MULHSU);
    end

    // Multiply: the signed rhs MSB carries weight -2^(XLEN-1), so its partial product subtracts.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        r_sh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = r_sh - {1'b0, mcand[XLEN-1:0]};
        acc_step = acc;
        if (r_is_div) begin
            if (!diff[XLEN])
                acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else if (r_is_cl) begin
            acc_step = acc ^ addend;
        end else if (sub_last && last) begin
            acc_step = acc - addend;
        end else begin
            acc_step = acc + addend;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = op_legal ? BUSY : DONE;
            BUSY: begin
                if (bus.flush)
                    state_n = IDLE;
                else if (last || (EARLY_DZ && dz))
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Divide keeps remainder in acc[2X-1:X] and shifts the quotient into acc[X-1:0].
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_r     <= '0;
            rs1_r    <= '0;
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
            count    <= '0;
            sub_last <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
        end else if (state == IDLE && accept) begin
            op_r  <= bus.op;
            rs1_r <= bus.rs1;
            count <= '0;
            if (op_is_div) begin
                acc      <= {{XLEN{1'b0}}, negate_if(bus.rs1, s1_in)};
                mcand    <= {{XLEN{1'b0}}, negate_if(bus.rs2, s2_in)};
                mplier   <= '0;
                sub_last <= 1'b0;
                neg_q    <= (bus.op == OP_DIV) && (s1_in != s2_in) && (bus.rs2 != '0);
                neg_r    <= (bus.op == OP_REM) && s1_in;
                dz       <= (bus.rs2 == '0);
            end else begin
                acc      <= '0;
                mcand    <= {{XLEN{mul_s1_in && bus.rs1[XLEN-1]}}, bus.rs1};
                mplier   <= bus.rs2;
                sub_last <= (bus.op == OP_MULH);
                neg_q    <= 1'b0;
                neg_r    <= 1'b0;
                dz       <= 1'b0;
            end
        end else if (state == BUSY && !bus.flush) begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (!r_is_div) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    always_comb begin
        bus.busy   = (state == BUSY);
        bus.ready  = (state == DONE);
        bus.result = (state == DONE) ? pick_result(op_r, acc, rs1_r, neg_q, neg_r, dz) : '0;
    end
endmodule
